// File: rtl/peripheral_responder.sv
// peripheral_responder: byte-writable register bank plus a free-running cycle counter, served over the peripheral read/write handshake.
module peripheral_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'hE000_0000,
  parameter int          NUM_REGS     = 16,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [31:0] WR_ADDR_TO_PERI,
  input  logic [31:0] DATA_TO_PERI,
  input  logic [3:0]  WSTRB,
  input  logic        WR_TO_PERI_VALID,
  output logic        WR_TO_PERI_READY,
  input  logic [31:0] RD_ADDR_TO_PERI,
  input  logic        RD_ADDR_TO_PERI_VALID,
  output logic        RD_ADDR_TO_PERI_READY,
  output logic [31:0] DATA_FROM_PERI,
  output logic        DATA_FROM_PERI_VALID,
  input  logic        DATA_FROM_PERI_READY,
  output logic        TRANSACTION_COMPLETE_PERI
);
  localparam int IW = $clog2(NUM_REGS + 1);
  localparam logic [31:0] LIMIT = BASE_ADDR + 32'(4 * (NUM_REGS + 1));
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA, COMPLETE} state_t;
  state_t state, state_n;
  logic [31:0] regs [NUM_REGS];
  logic [31:0] cnt, rd_word;
  logic [3:0] wait_cnt;
  logic [IW:0] rsel, wsel;
  logic rdy, wr_acc, rd_acc;
  // {mapped, word index}; index NUM_REGS is the counter
  function automatic logic [IW:0] decode(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return {a >= BASE_ADDR && a < LIMIT, off[IW+1:2]};
  endfunction
  assign wsel = decode(WR_ADDR_TO_PERI);
  assign WR_TO_PERI_READY = rdy;
  assign RD_ADDR_TO_PERI_READY = rdy;
  assign wr_acc = state == IDLE && rdy && WR_TO_PERI_VALID;
  assign rd_acc = state == IDLE && rdy && RD_ADDR_TO_PERI_VALID && !WR_TO_PERI_VALID;
  always_comb begin
    rd_word = ERR_DATA;
    if (rsel[IW] && rsel[IW-1:0] == IW'(NUM_REGS)) rd_word = cnt;
    for (int i = 0; i < NUM_REGS; i++)
      if (rsel[IW] && rsel[IW-1:0] == IW'(i)) rd_word = regs[i];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = wr_acc ? COMPLETE : rd_acc ? (READ_LATENCY == 0 ? RD_DATA : RD_WAIT) : IDLE;
      RD_WAIT:  state_n = wait_cnt == 4'd0 ? RD_DATA : RD_WAIT;
      RD_DATA:  state_n = DATA_FROM_PERI_VALID && DATA_FROM_PERI_READY ? COMPLETE : RD_DATA;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      cnt <= '0;
      rdy <= 1'b0;
      wait_cnt <= '0;
      rsel <= '0;
      DATA_FROM_PERI <= '0;
      DATA_FROM_PERI_VALID <= 1'b0;
      TRANSACTION_COMPLETE_PERI <= 1'b0;
    end else begin
      cnt <= cnt + 32'd1;
      rdy <= state == IDLE && !wr_acc && !rd_acc;
      TRANSACTION_COMPLETE_PERI <= state == COMPLETE;
      if (rd_acc) begin
        rsel <= decode(RD_ADDR_TO_PERI);
        wait_cnt <= 4'(READ_LATENCY - 1);
      end else if (state == RD_WAIT) wait_cnt <= wait_cnt - 4'd1;
      // data is captured once per read and then held until the handshake
      if (state == RD_DATA && !DATA_FROM_PERI_VALID) begin
        DATA_FROM_PERI_VALID <= 1'b1;
        DATA_FROM_PERI <= rd_word;
      end else if (DATA_FROM_PERI_VALID && DATA_FROM_PERI_READY) DATA_FROM_PERI_VALID <= 1'b0;
    end
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_acc && wsel[IW]) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wsel[IW-1:0] == IW'(i))
          for (int b = 0; b < 4; b++)
            if (WSTRB[b]) regs[i][8*b +: 8] <= DATA_TO_PERI[8*b +: 8];
    end
endmodule

// File: doc/peripheral_responder.md
# peripheral_responder

Bus responder for the pipeline's uncached peripheral channel. It accepts read and write address/data transfers from the core-side peripheral initiator and services them against a bank of byte-writable 32-bit registers plus one read-only cycle counter. It returns read data with a valid/ready handshake and signals the end of every transfer with a one-cycle completion pulse. It sits at the peripheral end of the link, opposite the core-side initiator, and is the standard target for memory-mapped control registers and for initiator verification.

## Interface
- BASE_ADDR, 32'hE000_0000: byte address of register 0; must be aligned to 4*(NUM_REGS+1) rounded up to a power of two.
- NUM_REGS, 16: number of read/write registers (2..64); the counter sits at word index NUM_REGS.
- READ_LATENCY, 2: wait cycles between read-address acceptance and data valid (0..15).
- ERR_DATA, 32'hDEAD_BEEF: read data returned for unmapped addresses.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- WR_ADDR_TO_PERI  in  32  write byte address.
- DATA_TO_PERI  in  32  write data.
- WSTRB  in  4  write byte strobes; bit i enables byte i.
- WR_TO_PERI_VALID  in  1  write address and data valid.
- WR_TO_PERI_READY  out  1  responder accepts a write.
- RD_ADDR_TO_PERI  in  32  read byte address.
- RD_ADDR_TO_PERI_VALID  in  1  read address valid.
- RD_ADDR_TO_PERI_READY  out  1  responder accepts a read address.
- DATA_FROM_PERI  out  32  read data.
- DATA_FROM_PERI_VALID  out  1  read data valid.
- DATA_FROM_PERI_READY  in  1  initiator accepts read data.
- TRANSACTION_COMPLETE_PERI  out  1  one-cycle pulse marking the end of a transfer.

## Operation
- States: IDLE, RD_WAIT, RD_DATA, COMPLETE.
- **IDLE.** Both READY outputs are 1.
  - WR_TO_PERI_VALID=1: write is accepted at that edge, both READYs drop, next state is COMPLETE.
  - Otherwise, RD_ADDR_TO_PERI_VALID=1: read is accepted, both READYs drop, address is captured, next state is RD_WAIT (READY_LATENCY>0, wait counter loaded with READ_LATENCY-1) or RD_DATA (latency 0).
  - Both valids high at the same edge: the write wins. The read stays pending and is accepted on the next return to IDLE.
- **RD_WAIT.** Counter decrements each cycle; at 0, next state is RD_DATA.
- **RD_DATA.**
  - DATA_FROM_PERI is loaded on entry with the addressed word and held stable while VALID=1.
  - On VALID & DATA_FROM_PERI_READY, VALID drops and next state is COMPLETE.
  - The responder waits indefinitely for READY.
- **COMPLETE.** TRANSACTION_COMPLETE_PERI=1 for exactly one cycle. Next state is IDLE and both READYs are set.
- **Address decode.**
  - word index = (addr - BASE_ADDR) >> 2; addr[1:0] are ignored.
  - Mapped when BASE_ADDR <= addr < BASE_ADDR + 4*(NUM_REGS+1).
- **Write effect** (at the acceptance edge):
  - Register at index < NUM_REGS: byte i is updated only where WSTRB[i]=1.
  - WSTRB=0, counter index, or unmapped address: no state change. The transfer still completes.
- **Read effect.**
  - Register index returns its contents; counter index returns its current value.
  - Unmapped returns ERR_DATA. The transfer still completes; no error signalling.
- **Counter.** 32-bit, increments every cycle out of reset, wraps 32'hFFFF_FFFF to 0, and cannot be written.

## Timing
- **Reset values** (RESETN low, asynchronous):
  - state IDLE; all registers 0; counter 0; DATA_FROM_PERI 0.
  - DATA_FROM_PERI_VALID 0; TRANSACTION_COMPLETE_PERI 0.
  - WR_TO_PERI_READY 0 and RD_ADDR_TO_PERI_READY 0. Both rise at the first CLK edge after RESETN deasserts.
- All outputs are registered; none depend combinationally on inputs.
- **Write latency:** handshake at edge E, register visible after E, completion pulse in cycle E+1, READYs high again from edge E+2.
- **Read latency:**
  - Handshake at edge E; DATA_FROM_PERI_VALID high from edge E+1+READ_LATENCY.
  - With READY already high, completion pulse one cycle after the data handshake edge.
- **Read-after-write same register:** returns the new value.
- **Counter read value** is sampled at the RD_DATA entry edge.
- **Reset mid-transfer:** transfer aborts, no completion pulse, all state returns to reset values.
- **Back-to-back:** minimum transfer spacing is 3 cycles for writes and 4+READ_LATENCY cycles for reads (from handshake to next handshake).

## Test plan
- **Reset:** hold RESETN low 5 cycles, release → READYs 0 during reset and 1 one edge after; all registers read 0; counter read ≈ cycles since release.
- **Full write:** write 32'h1234_5678, WSTRB=4'hF to BASE_ADDR+8 → completion pulse one cycle after handshake; read of BASE_ADDR+8 returns 32'h1234_5678 with VALID exactly READ_LATENCY+1 edges after address handshake.
- **Partial strobe:** write 32'hAABB_CCDD, WSTRB=4'b0101 over 32'h1111_1111 → read returns 32'h11BB_11DD; WSTRB=0 write leaves the value unchanged but still pulses complete.
- **Read-data backpressure:** hold DATA_FROM_PERI_READY low 10 cycles → VALID and data stay stable, no completion pulse; completion pulse arrives one cycle after READY rises.
- **Collision and unmapped:**
  - Assert write and read valid on the same edge → write completes first, then read is accepted.
  - Read of BASE_ADDR+4*(NUM_REGS+1) → ERR_DATA.
  - Write to the counter index → counter unaffected.
- **Abort:** assert RESETN low during RD_WAIT → no VALID, no completion pulse, clean IDLE after release; a subsequent write/read pair completes normally.
